// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key indices and receiver state encoding
// for the PS/2 keyboard front end.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_BAT   = 8'hAA;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_JUMP  = 4;
    localparam int NUM_KEYS  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // One-hot key mask for a scan code; all-zero means unmapped.
    function automatic logic [NUM_KEYS-1:0] key_mask(
        input logic       ext,
        input logic [7:0] code
    );
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[KEY_UP]    = 1'b1;
                SC_DOWN:  m[KEY_DOWN]  = 1'b1;
                SC_LEFT:  m[KEY_LEFT]  = 1'b1;
                SC_RIGHT: m[KEY_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_W:     m[KEY_UP]    = 1'b1;
                SC_S:     m[KEY_DOWN]  = 1'b1;
                SC_A:     m[KEY_LEFT]  = 1'b1;
                SC_D:     m[KEY_RIGHT] = 1'b1;
                SC_SPACE: m[KEY_JUMP]  = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: synchronisers, ps2c falling-edge detect,
// frame FSM with parity/stop checks and inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] c_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic                   c_prev;
    logic                   c_s;
    logic                   d_s;
    logic                   fall;

    rx_state_t     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    assign c_s  = c_sync[SYNC_STAGES-1];
    assign d_s  = d_sync[SYNC_STAGES-1];
    assign fall = c_prev & ~c_s;

    // Idle-high reset values keep reset release from faking an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_sync <= '1;
            d_sync <= '1;
            c_prev <= 1'b1;
        end else begin
            c_sync <= {c_sync[SYNC_STAGES-2:0], ps2c};
            d_sync <= {d_sync[SYNC_STAGES-2:0], ps2d};
            c_prev <= c_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!d_s) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = {d_s, shift_q[7:1]};
                    if (cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = d_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (d_s && (^shift_q ^ par_q)) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: tracks E0/F0 prefixes and maintains a held-key
// bitmap usable in place of the debounced button bus.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [4:0] keydown,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [4:0] kd_q, kd_d;
    logic [4:0] mask;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .ps2c    (ps2c),
        .ps2d    (ps2d),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign mask = key_mask(ext_q, rx_byte);

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        kd_d  = kd_q;
        unique case (1'b1)
            rx_err: begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
            rx_valid: begin
                if (rx_byte == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (rx_byte == SC_BREAK) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (rx_byte == SC_BAT) begin
                        kd_d = '0;
                    end else if (brk_q) begin
                        kd_d = kd_q & ~mask;
                    end else begin
                        kd_d = kd_q | mask;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            kd_q  <= '0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            kd_q  <= kd_d;
        end
    end

    assign keydown    = kd_q;
    assign scan_code  = rx_byte;
    assign code_valid = rx_valid;
    assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: scripted scenarios plus
// randomized frames against a frame-level key-state model.
module tb_ps2_key_decoder;

    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [4:0] keydown;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_v = 0;
    int cnt_e = 0;

    logic [4:0] m_kd   = '0;
    logic [7:0] m_scan = '0;
    bit         m_ext  = 0;
    bit         m_brk  = 0;
    int         map_std[int];
    int         map_ext[int];
    logic [7:0] exp_q[$];
    logic       cv_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .keydown   (keydown),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Every code_valid cycle must carry the next expected good byte.
    always @(negedge clk) begin
        if (!rst) begin
            cv_prev = 1'b0;
        end else begin
            if (code_valid) begin
                cnt_v++;
                chk("cv_width", 32'(cv_prev), 0);
                chk("cv_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    chk("cv_scan", 32'(scan_code), 32'(exp_q.pop_front()));
            end
            if (frame_err) begin
                cnt_e++;
                chk("err_excl", 32'(code_valid), 0);
            end
            cv_prev = code_valid;
        end
    end

    task automatic model_byte(input logic [7:0] b);
        int idx;
        m_scan = b;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (b == 8'hAA) m_kd = '0;
            else begin
                idx = -1;
                if (m_ext && map_ext.exists(int'(b))) idx = map_ext[int'(b)];
                if (!m_ext && map_std.exists(int'(b))) idx = map_std[int'(b)];
                if (idx >= 0) m_kd[idx] = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic edge_bit(input logic v);
        ps2d = v;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bpar,
                             input bit bstop, input int n);
        logic [10:0] f;
        f = {~bstop, (~^b) ^ bpar, b, 1'b0};
        for (int i = 0; i < n; i++) edge_bit(f[i]);
        ps2d = 1'b1;
    endtask

    task automatic settle_check(input int ev, input int ee);
        repeat (6) @(posedge clk);
        #1;
        chk("valid_cnt", cnt_v, ev);
        chk("err_cnt", cnt_e, ee);
        chk("scan_code", 32'(scan_code), 32'(m_scan));
        chk("keydown", 32'(keydown), 32'(m_kd));
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bpar,
                            input bit bstop);
        bit good;
        good = !bpar && !bstop;
        cnt_v = 0;
        cnt_e = 0;
        if (good) exp_q.push_back(b);
        send_bits(b, bpar, bstop, 11);
        if (good) model_byte(b);
        else begin
            m_ext = 0;
            m_brk = 0;
        end
        settle_check(good ? 1 : 0, good ? 0 : 1);
    endtask

    logic [7:0] pool[14];

    initial begin
        map_ext[8'h75] = 0; map_ext[8'h72] = 1;
        map_ext[8'h6B] = 2; map_ext[8'h74] = 3;
        map_std[8'h1D] = 0; map_std[8'h1B] = 1; map_std[8'h1C] = 2;
        map_std[8'h23] = 3; map_std[8'h29] = 4;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
                 8'h1B, 8'h1C, 8'h23, 8'h29, 8'hAA, 8'hE1, 8'h00};

        repeat (4) @(posedge clk);
        #1;
        chk("rst_keydown", 32'(keydown), 0);
        chk("rst_scan", 32'(scan_code), 0);
        chk("rst_cv", 32'(code_valid), 0);
        chk("rst_fe", 32'(frame_err), 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        do_frame(8'hE0, 0, 0);
        do_frame(8'h75, 0, 0);
        chk("lit_up", 32'(keydown), 32'h01);
        chk("lit_scan75", 32'(scan_code), 32'h75);
        do_frame(8'hE0, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h75, 0, 0);
        chk("lit_up_rel", 32'(keydown), 32'h00);

        do_frame(8'h29, 0, 0);
        do_frame(8'h1C, 0, 0);
        chk("lit_jl", 32'(keydown), 32'h14);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h29, 0, 0);
        chk("lit_l", 32'(keydown), 32'h04);

        do_frame(8'h1D, 1, 0);
        chk("lit_badpar", 32'(keydown), 32'h04);
        chk("lit_badpar_sc", 32'(scan_code), 32'h29);
        do_frame(8'h1D, 0, 0);
        chk("lit_w", 32'(keydown), 32'h05);

        cnt_v = 0;
        cnt_e = 0;
        send_bits(8'h1D, 0, 0, 5);
        m_ext = 0;
        m_brk = 0;
        repeat (TMO - 60) @(posedge clk);
        #1;
        chk("tmo_early", cnt_e, 0);
        settle_check(0, 0);
        repeat (100) @(posedge clk);
        #1;
        chk("tmo_err", cnt_e, 1);
        chk("tmo_valid", cnt_v, 0);
        do_frame(8'h23, 0, 0);
        chk("lit_d", 32'(keydown), 32'h0D);

        do_frame(8'h1B, 0, 0);
        do_frame(8'h29, 0, 0);
        chk("lit_all", 32'(keydown), 32'h1F);
        do_frame(8'hAA, 0, 0);
        chk("lit_bat", 32'(keydown), 32'h00);
        do_frame(8'hE0, 0, 0);
        do_frame(8'h29, 0, 0);
        chk("lit_e0_29", 32'(keydown[4]), 0);
        do_frame(8'h75, 0, 0);
        chk("lit_kp75", 32'(keydown), 32'h00);

        do_frame(8'hE0, 0, 0);
        cnt_v = 0;
        cnt_e = 0;
        edge_bit(1'b1);
        m_ext = 0;
        m_brk = 0;
        settle_check(0, 1);
        do_frame(8'h75, 0, 0);
        chk("lit_starterr", 32'(keydown), 32'h00);
        do_frame(8'h1D, 0, 1);

        do_frame(8'h29, 0, 0);
        do_frame(8'hE0, 0, 0);
        send_bits(8'h75, 0, 0, 5);
        rst = 1'b0;
        #1;
        chk("mid_rst_kd", 32'(keydown), 0);
        chk("mid_rst_sc", 32'(scan_code), 0);
        chk("mid_rst_cv", 32'(code_valid), 0);
        chk("mid_rst_fe", 32'(frame_err), 0);
        m_kd = '0;
        m_scan = '0;
        m_ext = 0;
        m_brk = 0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_frame(8'h75, 0, 0);
        chk("lit_post_rst", 32'(keydown), 0);

        for (int i = 0; i < 70; i++) begin
            logic [7:0] b;
            int r;
            b = pool[$urandom_range(0, 13)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 19);
            do_frame(b, r == 0, r == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
